// File: rtl/uart_pkg.sv
// Shared types and constants for the word-oriented UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS      = 8;
  localparam int BYTES_PER_WORD = 4;

  // Clock cycles spent on each serial bit.
  function automatic int bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry and a
// synchronous flush that overrides any push or pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; flush returns everything to empty.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Control state register.
  always_ff @(posedge CLK or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage.
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, so stale contents are never observed.
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_word_tx.sv
// Word-oriented 8N1 UART transmitter: each 32-bit word is sent as four byte
// frames, least-significant byte first, back to back with no idle gap while
// words remain queued.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic [31:0]                   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          abort,
  output logic                          TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   words_sent
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic             tx_q, tx_d;
  logic [15:0]      words_sent_q, words_sent_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]      fifo_rdata;
  logic [7:0]       cur_byte;

  assign in_ready   = !fifo_full && !abort;
  assign fifo_push  = in_valid && in_ready;
  assign cur_byte   = word_q[{byte_idx_q, 3'b000} +: 8];
  assign TX         = tx_q;
  assign words_sent = words_sent_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .flush (abort),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame sequencing: next state, next line level, pops and word count.
  always_comb begin
    state_d      = state_q;
    baud_d       = (baud_q != '0) ? baud_q - CNT_W'(1) : baud_q;
    bit_idx_d    = bit_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    tx_d         = tx_q;
    words_sent_d = words_sent_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          word_d     = fifo_rdata;
          byte_idx_d = '0;
          baud_d     = CNT_LOAD;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d   = DATA;
          bit_idx_d = '0;
          baud_d    = CNT_LOAD;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = CNT_LOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          baud_d = CNT_LOAD;
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            words_sent_d = words_sent_q + 16'd1;
            if (!fifo_empty) begin
              // Next word starts straight after this stop bit.
              fifo_pop   = 1'b1;
              word_d     = fifo_rdata;
              byte_idx_d = '0;
              state_d    = START;
              tx_d       = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Abort drops the word in flight without counting it.
    if (abort) begin
      state_d      = IDLE;
      tx_d         = 1'b1;
      baud_d       = '0;
      fifo_pop     = 1'b0;
      words_sent_d = words_sent_q;
    end
  end

  // Transmitter state register; TX comes straight from a flop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      tx_q         <= 1'b1;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      tx_q         <= tx_d;
      words_sent_q <= words_sent_d;
    end
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Word-oriented UART transmitter that serialises 32-bit words as four 8N1 byte frames, least-significant byte first.
- Its framing and byte order match the CPU-side UART receive/program-load path, so a stream of words from this block lands in instruction memory word-for-word.
- Sits on the loader/host side. Words arrive on a valid/ready port and are buffered in a small FIFO.

Parameters:
- CLK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s.
- BIT_CYCLES, CLK_FREQ/BAUD_RATE (localparam), clock cycles per bit; must be >= 2.
- FIFO_DEPTH, 4, word FIFO entries; power of two, >= 2.

Ports:
- CLK  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  32  word to transmit
- in_valid  input  1  in_data valid
- in_ready  output  1  FIFO can accept a word
- abort  input  1  synchronous flush/abort, active-high
- TX  output  1  serial line, idle high
- busy  output  1  FIFO non-empty or frame in progress
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words queued, not yet started
- words_sent  output  16  count of fully transmitted words

Behaviour:
- Reset values: TX=1, busy=0, in_ready=1, fifo_count=0, words_sent=0, FSM=IDLE.
- Reset takes effect immediately, even mid-frame.
- Push happens on a rising edge when in_valid && in_ready.
  - in_ready = !full && !abort (combinational).
  - When the FIFO is full, no push is accepted, even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - TX=1.
  - If the FIFO is non-empty: pop the head word into the shift register, set byte_idx=0, load bit counter, go to START.
- START: TX=0 for BIT_CYCLES cycles, then go to DATA with bit_idx=0.
- DATA:
  - TX=current byte bit[bit_idx], LSB first, for BIT_CYCLES cycles per bit.
  - After bit 7, go to STOP.
- STOP: TX=1 for BIT_CYCLES cycles. At the end:
  - If byte_idx<3: byte_idx++, select byte in_word[8*byte_idx+:8], go to START with no idle gap.
  - If byte_idx==3: words_sent++ (wraps 0xFFFF->0).
    - If the FIFO is non-empty: pop and go to START directly, with no idle bit between words.
    - Otherwise go to IDLE.
- TX is registered.
- Latency, starting from IDLE with an empty FIFO:
  - The accepting edge is N.
  - The pop occurs at edge N+1.
  - TX falls at edge N+1 and is low for cycles N+1 .. N+BIT_CYCLES.
- Frame length: exactly 10*BIT_CYCLES cycles per byte, 40*BIT_CYCLES per word.
- Baud counter:
  - Counts BIT_CYCLES-1 down to 0; the bit advances at 0.
  - Width $clog2(BIT_CYCLES).
- abort (synchronous):
  - On the next edge: FIFO emptied, FSM to IDLE, TX=1.
  - The partial word is discarded and words_sent is not incremented.
  - Overrides a simultaneous push and pop.
- busy = (FSM != IDLE) || (fifo_count != 0).
- fifo_count counts entries in the FIFO only. The word being shifted is not counted.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - DATA_BITS=8, BYTES_PER_WORD=4.
  - Helper function bit_cycles(clk_freq, baud_rate).
- Sub-module sync_fifo:
  - Parameterised width/depth.
  - Interface: push, pop, full, empty, count.
  - Flush on abort.
- Top level holds the FSM, baud counter, shift/byte select and words_sent.

Test Plan (CLK_FREQ=8, BAUD_RATE=1 -> BIT_CYCLES=8):
- Reset check: assert reset mid-frame -> TX=1, busy=0, in_ready=1, fifo_count=0, words_sent=0 immediately.
- Single word: push 0xA5C30F81 while idle.
  - TX low exactly 8 cycles starting at edge N+1.
  - Byte sequence decoded 0x81, 0x0F, 0xC3, 0xA5.
  - Byte 0 bits 1,0,0,0,0,0,0,1.
  - 320 cycles total, then words_sent=1, busy=0.
- Back-to-back: push 0x00000000 then 0xFFFFFFFF -> 640 contiguous cycles with no idle gap; words_sent=2.
- Full FIFO: while word 0 is transmitting, push 5 more words.
  - in_ready=0 once fifo_count=4.
  - The 5th push is held until the next pop.
  - All 6 words come out in order.
- Abort: assert abort during byte 2 of the first word with 3 words queued.
  - Next edge: TX=1, fifo_count=0, busy=0, words_sent unchanged.
  - A push in the same cycle is not accepted.
- Counter wrap: force 65536 short-word completions (or preload via bench hook) -> words_sent wraps to 0.
